// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - RV32 R/I-type ALU decode stage with a one-entry output register.
// Decodes fields into an ALU op and operand pair, flags illegal encodings, counts issued ops.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  alu_op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        illegal,
    output logic [15:0] issue_count
);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e      state_q;
    logic [2:0]  alu_op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        illegal_q;
    logic [15:0] count_q;
    logic [15:0] count_d;

    logic        is_r;
    logic        is_i;
    logic        f7_zero;
    logic        f7_alt;
    logic        dec_legal;
    logic [2:0]  dec_op;
    logic [31:0] dec_b;
    logic        accept;
    logic        consume;

    assign out_valid   = (state_q == FULL);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign consume     = out_valid && out_ready;
    assign alu_op      = alu_op_q;
    assign a           = a_q;
    assign b           = b_q;
    assign illegal     = illegal_q;
    assign issue_count = count_q;

    assign is_r    = (opcode == OPC_R);
    assign is_i    = (opcode == OPC_I);
    assign f7_zero = (funct7 == F7_ZERO);
    assign f7_alt  = (funct7 == F7_ALT);

    // For I-type non-shift ops funct7 is just imm[11:5], so it is not constrained.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_b     = is_r ? rs2_data : imm;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: begin
                    dec_legal = is_i || f7_zero || f7_alt;
                    dec_op    = (is_r && f7_alt) ? OP_SUB : OP_ADD;
                end
                3'b001: begin
                    dec_legal = f7_zero;
                    dec_op    = OP_SLL;
                    if (is_i) dec_b = {27'b0, imm[4:0]};
                end
                3'b100: begin
                    dec_legal = is_i || f7_zero;
                    dec_op    = OP_XOR;
                end
                3'b101: begin
                    dec_legal = f7_zero || f7_alt;
                    dec_op    = f7_alt ? OP_SRA : OP_SRL;
                    if (is_i) dec_b = {27'b0, imm[4:0]};
                end
                3'b110: begin
                    dec_legal = is_i || f7_zero;
                    dec_op    = OP_OR;
                end
                3'b111: begin
                    dec_legal = is_i || f7_zero;
                    dec_op    = OP_AND;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign count_d = (consume && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            alu_op_q  <= OP_ADD;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            illegal_q <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            illegal_q <= accept && !dec_legal;
            count_q   <= count_d;
            // A legal accept always (re)loads; otherwise a consume drains to EMPTY.
            case (state_q)
                EMPTY: begin
                    if (accept && dec_legal) begin
                        state_q  <= FULL;
                        alu_op_q <= dec_op;
                        a_q      <= rs1_data;
                        b_q      <= dec_b;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (accept && dec_legal) begin
                            alu_op_q <= dec_op;
                            a_q      <= rs1_data;
                            b_q      <= dec_b;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - self-checking bench for alu_ctrl against a behavioural model.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;
    logic [15:0] issue_count;

    int checks   = 0;
    int failures = 0;

    // Model of the visible state.
    logic        m_valid;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_ill;
    int          m_cnt;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .a(a), .b(b), .illegal(illegal), .issue_count(issue_count)
    );

    // Instruction semantics by mnemonic: returns ALU op code and operands.
    task automatic ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                              output logic ok, output logic [2:0] op,
                              output logic [31:0] ea, output logic [31:0] eb);
        bit rt, it, shift;
        rt    = (opc == 7'h33);
        it    = (opc == 7'h13);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        ok = 1'b0; op = 3'd0; ea = r1;
        eb = rt ? r2 : (shift ? (im & 32'h1F) : im);
        if (rt || it) begin
            if (f3 == 3'd2 || f3 == 3'd3)            ok = 1'b0;
            else if (f3 == 3'd5)                     ok = (f7 == 7'h00 || f7 == 7'h20);
            else if (f3 == 3'd1)                     ok = (f7 == 7'h00);
            else if (it)                             ok = 1'b1;
            else if (f3 == 3'd0)                     ok = (f7 == 7'h00 || f7 == 7'h20);
            else                                     ok = (f7 == 7'h00);
            case (f3)
                3'd0: op = (rt && f7 == 7'h20) ? 3'd1 : 3'd0;
                3'd1: op = 3'd2;
                3'd4: op = 3'd5;
                3'd5: op = (f7 == 7'h20) ? 3'd6 : 3'd7;
                3'd6: op = 3'd4;
                3'd7: op = 3'd3;
                default: op = 3'd0;
            endcase
        end
    endtask

    // Advance one clock and the model alongside it; no comparisons here.
    task automatic tick();
        bit acc, cons, ok;
        logic [2:0]  op;
        logic [31:0] ea, eb;
        acc  = in_valid && (!m_valid || out_ready);
        cons = m_valid && out_ready;
        ref_decode(opcode, funct3, funct7, rs1_data, rs2_data, imm, ok, op, ea, eb);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_ill = 0; m_cnt = 0;
        end else begin
            m_ill = acc && !ok;
            if (cons && m_cnt < 65535) m_cnt++;
            if (acc && ok) begin
                m_valid = 1; m_op = op; m_a = ea; m_b = eb;
            end else if (cons) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        opcode = opc; funct3 = f3; funct7 = f7; rs1_data = r1; rs2_data = r2; imm = im;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0;
        set_instr(7'h33, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        rst = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        checks++; if (issue_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", issue_count); end
        checks++; if ({alu_op, a, b} !== 67'd0) begin failures++; $display("FAIL reset_fields got=%0d/%0h/%0h exp=0/0/0", alu_op, a, b); end
    endtask

    task automatic test_sub();
        set_instr(7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0);
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || alu_op !== 3'b001 || a !== 32'd10 || b !== 32'd3) begin
            failures++; $display("FAIL sub_issue got=%b/%0d/%0d/%0d exp=1/1/10/3", out_valid, alu_op, a, b); end
        tick();
        checks++; if (issue_count !== 16'd1) begin failures++; $display("FAIL sub_count got=%0d exp=1", issue_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sub_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_srai();
        set_instr(7'h13, 3'd5, 7'h20, 32'hF000_0000, 32'd0, 32'h0000_0405);
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || alu_op !== 3'b110 || b !== 32'd5 || a !== 32'hF000_0000) begin
            failures++; $display("FAIL srai got=%b/%0d/%0h/%0h exp=1/6/f0000000/5", out_valid, alu_op, a, b); end
        tick();
    endtask

    task automatic test_backpressure();
        int c0;
        c0 = m_cnt;
        set_instr(7'h33, 3'd0, 7'h00, 32'd7, 32'd8, 32'd0);
        in_valid = 1; out_ready = 0;
        tick();
        set_instr(7'h13, 3'd4, 7'h11, 32'd100, 32'd0, 32'h0000_0234);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || alu_op !== 3'd0 || a !== 32'd7 || b !== 32'd8 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%0d/%0d rdy=%b exp=1/0/7/8 rdy=0", i, out_valid, alu_op, a, b, in_ready); end
            checks++; if (issue_count !== 16'(c0)) begin failures++; $display("FAIL bp_count[%0d] got=%0d exp=%0d", i, issue_count, c0); end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (issue_count !== 16'(c0 + 1)) begin failures++; $display("FAIL bp_release_count got=%0d exp=%0d", issue_count, c0 + 1); end
        checks++; if (out_valid !== 1'b1 || alu_op !== 3'd5 || a !== 32'd100 || b !== 32'h234) begin
            failures++; $display("FAIL bp_reload got=%b/%0d/%0d/%0h exp=1/5/100/234", out_valid, alu_op, a, b); end
        tick();
    endtask

    task automatic test_illegal();
        int c0;
        c0 = m_cnt;
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_instr(7'h33, 3'd2, 7'h00, 32'd1, 32'd2, 32'd0);
            else        set_instr(7'h03, 3'd0, 7'h00, 32'd1, 32'd2, 32'd4);
            in_valid = 1;
            tick();
            in_valid = 0;
            checks++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin
                failures++; $display("FAIL illegal_pulse[%0d] got=%b/%b exp=1/0", k, illegal, out_valid); end
            tick();
            checks++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin
                failures++; $display("FAIL illegal_clear[%0d] got=%b/%b exp=0/0", k, illegal, out_valid); end
        end
        checks++; if (issue_count !== 16'(c0)) begin failures++; $display("FAIL illegal_count got=%0d exp=%0d", issue_count, c0); end
    endtask

    task automatic test_back_to_back();
        rst = 1; in_valid = 0; tick(); rst = 0;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(7'h33, 3'(i == 0 ? 7 : (i == 1 ? 6 : 4)), 7'h00, 32'(i + 1), 32'(i + 20), 32'd0);
            tick();
            checks++; if (out_valid !== 1'b1 || a !== 32'(i + 1) || b !== 32'(i + 20)) begin
                failures++; $display("FAIL b2b[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, out_valid, a, b, i + 1, i + 20); end
        end
        in_valid = 0;
        tick();
        checks++; if (issue_count !== 16'd3 || out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_count got=%0d/%b exp=3/0", issue_count, out_valid); end
    endtask

    task automatic test_reset_full();
        set_instr(7'h33, 3'd0, 7'h00, 32'd5, 32'd6, 32'd0);
        in_valid = 1; out_ready = 0;
        tick();
        rst = 1;
        tick();
        rst = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || issue_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_full got=%b/%0d/%b exp=0/0/1", out_valid, issue_count, in_ready); end
    endtask

    task automatic test_random();
        logic [6:0] opcs [3] = '{7'h33, 7'h13, 7'h00};
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            opcode    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 1)];
            funct3    = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    funct7 = 7'h00;
                2:       funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
            #1;
            checks++; if (in_ready !== (!m_valid || out_ready)) begin
                failures++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, !m_valid || out_ready); end
            tick();
            checks++; if (out_valid !== m_valid || illegal !== m_ill || issue_count !== 16'(m_cnt)) begin
                failures++; $display("FAIL rnd_ctrl[%0d] got=%b/%b/%0d exp=%b/%b/%0d", i, out_valid, illegal, issue_count, m_valid, m_ill, m_cnt); end
            checks++; if (alu_op !== m_op || a !== m_a || b !== m_b) begin
                failures++; $display("FAIL rnd_fields[%0d] got=%0d/%h/%h exp=%0d/%h/%h", i, alu_op, a, b, m_op, m_a, m_b); end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_sub();
        test_srai();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream decoded-instruction fields valid.
REQ-005 in_ready  output  1  block can accept fields this cycle.
REQ-006 opcode  input  7  RV32 opcode; funct3 input 3; funct7 input 7 (imm[11:5] for I-type).
REQ-007 rs1_data, rs2_data, imm  input  32 each  operand sources.
REQ-008 out_valid  output  1  alu_op/a/b hold a legal issued operation.
REQ-009 out_ready  input  1  downstream ALU stage consumes the output this cycle.
REQ-010 alu_op  output  3  ALU op: 000 ADD, 001 SUB, 010 SLL, 011 AND, 100 OR, 101 XOR, 110 SRA, 111 SRL.
REQ-011 a, b  output  32 each  ALU operands.
REQ-012 illegal  output  1  one-cycle pulse: an accepted instruction was not decodable.
REQ-013 issue_count  output  16  saturating count of legal operations consumed downstream.

Function
REQ-014 Output register states SHALL be EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 Accept SHALL occur on a cycle with in_valid && in_ready; accepted fields SHALL appear on the outputs the next cycle (latency 1, throughput 1/cycle).
REQ-017 R-type (opcode 0110011): a=rs1_data, b=rs2_data.
REQ-018 I-type (opcode 0010011): a=rs1_data; b=imm, except shifts (funct3 001/101) where b={27'b0, imm[4:0]}.
REQ-019 funct3 decode: 000 -> ADD (SUB only for R-type with funct7=0100000); 001 -> SLL; 100 -> XOR; 101 -> SRL (funct7=0000000) or SRA (funct7=0100000); 110 -> OR; 111 -> AND.
REQ-020 Illegal: any other opcode; funct3 010/011; R-type funct7 not 0000000 (or 0100000 where REQ-019 permits); funct3 001 with funct7 != 0000000; funct3 101 with any other funct7; I-type funct3 000 ignores funct7.
REQ-021 An accepted illegal instruction SHALL pulse illegal for exactly one cycle following the accept and SHALL NOT set out_valid; if the accept cycle also consumed a FULL output, the next state is EMPTY.
REQ-022 While out_valid && !out_ready, alu_op, a, b and out_valid SHALL remain stable; in_ready=0.
REQ-023 Simultaneous consume (out_ready) and legal accept SHALL reload the register with new fields, keeping out_valid=1 with no bubble.
REQ-024 issue_count SHALL increment by 1 on each cycle with out_valid && out_ready; it saturates at 16'hFFFF.
REQ-025 In EMPTY, alu_op, a and b SHALL hold their last values (don't-care to downstream).

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, illegal=0, alu_op=3'b000, a=0, b=0, issue_count=0; in_ready=1 after reset.
REQ-027 rst SHALL override any simultaneous accept or consume; a FULL output is discarded without being counted.

Verification
REQ-028 R-type SUB: opcode=0110011, funct3=000, funct7=0100000, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, alu_op=001, a=10, b=3; issue_count=1 the cycle after.
REQ-029 I-type SRAI: opcode=0010011, funct3=101, funct7=0100000, imm=32'h0000_0405 -> alu_op=110, b=5.
REQ-030 Backpressure: load ADD, hold out_ready=0 for 4 cycles with new in_valid -> outputs stable, in_ready=0, issue_count unchanged; raise out_ready -> count+1 and next op loads same cycle.
REQ-031 Illegal SLT (funct3=010) and opcode 0000011 -> illegal pulses one cycle each, out_valid stays 0, issue_count unchanged.
REQ-032 Back-to-back 3 legal ops with out_ready=1 -> out_valid high 3 consecutive cycles, issue_count=3.
REQ-033 Reset while FULL with out_ready=0 -> next cycle out_valid=0, issue_count=0, in_ready=1.
